decode: RTL

//  Instruction decode stage for the LC3 core, directly downstream of fetch.

---
 rtl/decode.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/decode.sv
// -----------------------------------------------------------------------------
// decode: LC3 instruction decode stage, directly downstream of fetch.
//
// After fetch pulses decode_start (its addr_out is on the instruction BRAM),
// this block waits MEM_LAT cycles for the BRAM read, latches the returned word
// into IR, and splits it into fields with the immediates sign-extended. The
// fields are offered to execute with a valid/ready handshake. opCode_out,
// offset9_out and br_nzp_out also feed fetch.
//
// Parameters
//   MEM_LAT       BRAM read latency in cycles, 1..4
//
// Ports
//   clk           system clock, all state on the rising edge
//   rst_n         asynchronous active-low reset
//   decode_start  1-cycle pulse from fetch: next instruction address driven
//   pc_in         fetch NPC, captured at decode_start
//   mem_dout      instruction BRAM read data
//   exec_ready    execute can accept the decoded instruction
//   decode_valid  decoded fields valid, held until exec_ready
//   decode_busy   high whenever the FSM is not idle
//   ir_out        latched instruction register
//   npc_out       pc_in captured at decode_start
//   opCode_out    IR[15:12]
//   dr_out        IR[11:9]
//   sr1_out       IR[8:6]
//   sr2_out       IR[2:0]
//   imm_mode      IR[5] for ADD/AND, else 0
//   imm5_sext     sign-extended IR[4:0]
//   offset6_sext  sign-extended IR[5:0]
//   offset9_out   raw IR[8:0]
//   br_nzp_out    IR[11:9] for BR, else 000
//   illegal_op    reserved opcode 1101
//   state_dbg     current FSM state, for debug/checkers
// -----------------------------------------------------------------------------
module decode #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        decode_start,
    input  logic [15:0] pc_in,
    input  logic [15:0] mem_dout,
    input  logic        exec_ready,
    output logic        decode_valid,
    output logic        decode_busy,
    output logic [15:0] ir_out,
    output logic [15:0] npc_out,
    output logic [3:0]  opCode_out,
    output logic [2:0]  dr_out,
    output logic [2:0]  sr1_out,
    output logic [2:0]  sr2_out,
    output logic        imm_mode,
    output logic [15:0] imm5_sext,
    output logic [15:0] offset6_sext,
    output logic [8:0]  offset9_out,
    output logic [2:0]  br_nzp_out,
    output logic        illegal_op,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_LATCH = 2'd2,
        S_ISSUE = 2'd3
    } state_t;

    // Counter load so that WAIT lasts exactly MEM_LAT cycles (exit when 0).
    localparam logic [1:0] WAIT_LOAD = 2'(MEM_LAT - 1);

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_RSV = 4'b1101;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  wait_cnt;
    logic [3:0]  mem_op;

    assign mem_op = mem_dout[15:12];

    // Handshake: decode_valid is high for every cycle spent in ISSUE and the
    // fields are stable while it is high. A transfer happens on a rising edge
    // where decode_valid and exec_ready are both 1; decode_valid drops right
    // after that edge. Valid never depends combinationally on exec_ready.
    assign decode_valid = (state == S_ISSUE);
    assign decode_busy  = (state != S_IDLE);
    assign state_dbg    = state;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. decode_start outside IDLE (including the ISSUE cycle
    // that transfers) is dropped; there is no queueing.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (decode_start) state_nxt = S_WAIT;
            S_WAIT:  if (wait_cnt == 2'd0) state_nxt = S_LATCH;
            S_LATCH: state_nxt = S_ISSUE;
            S_ISSUE: if (exec_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // BRAM latency counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 2'd0;
        end else if (state == S_IDLE && decode_start) begin
            wait_cnt <= WAIT_LOAD;
        end else if (state == S_WAIT && wait_cnt != 2'd0) begin
            wait_cnt <= wait_cnt - 2'd1;
        end
    end

    // NPC capture at the accepted decode_start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            npc_out <= 16'h0000;
        end else if (state == S_IDLE && decode_start) begin
            npc_out <= pc_in;
        end
    end

    // IR and fields are registered straight from mem_dout on the LATCH edge
    // so they line up with IR; they then hold until the next LATCH so that
    // execute/fetch may sample them after the transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_out       <= 16'h0000;
            opCode_out   <= 4'h0;
            dr_out       <= 3'b000;
            sr1_out      <= 3'b000;
            sr2_out      <= 3'b000;
            imm_mode     <= 1'b0;
            imm5_sext    <= 16'h0000;
            offset6_sext <= 16'h0000;
            offset9_out  <= 9'h000;
            br_nzp_out   <= 3'b000;
            illegal_op   <= 1'b0;
        end else if (state == S_LATCH) begin
            ir_out       <= mem_dout;
            opCode_out   <= mem_op;
            dr_out       <= mem_dout[11:9];
            sr1_out      <= mem_dout[8:6];
            sr2_out      <= mem_dout[2:0];
            imm_mode     <= (mem_op == OP_ADD || mem_op == OP_AND) ? mem_dout[5] : 1'b0;
            imm5_sext    <= {{11{mem_dout[4]}}, mem_dout[4:0]};
            offset6_sext <= {{10{mem_dout[5]}}, mem_dout[5:0]};
            offset9_out  <= mem_dout[8:0];
            br_nzp_out   <= (mem_op == OP_BR) ? mem_dout[11:9] : 3'b000;
            illegal_op   <= (mem_op == OP_RSV);
        end
    end

endmodule
